// File: rtl/hps_command_decoder.sv
// HPS command front-end: strobe synchroniser, 4-phase handshake FSM, command decode and status word.
// Optional HPS_CMD_COUNT_EN: status[31:16] counts acked commands.
module hps_command_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 15,
    parameter int PIX_W       = 8,
    parameter int RAM_DEPTH   = 19200
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [31:0]       hps_data_in,
    input  logic              hps_control_in,
    input  logic              controller_done,
    input  logic [2:0]        controller_zoom_level,
    output logic [31:0]       fpga_status_out,
    output logic              cmd_reset_pulse,
    output logic              cmd_zoom_in_pulse,
    output logic              cmd_zoom_out_pulse,
    output logic              cmd_return_pulse,
    output logic [1:0]        cmd_algorithm_select,
    output logic              cmd_multiple_sw_error,
    output logic              cmd_no_sw_error,
    output logic [ADDR_W-1:0] ram_wraddress,
    output logic [PIX_W-1:0]  ram_data_in,
    output logic              ram_wren,
    output logic [1:0]        debug_state
);

    // Handshake: HPS raises hps_control_in with hps_data_in stable, waits for ack=1,
    // drops the strobe, and the decoder clears ack once the low strobe is seen.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        EXEC     = 2'd2,
        ACK_WAIT = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP       = 4'd0;
    localparam logic [3:0] OP_RESET     = 4'd1;
    localparam logic [3:0] OP_ZOOM_IN   = 4'd2;
    localparam logic [3:0] OP_ZOOM_OUT  = 4'd3;
    localparam logic [3:0] OP_RETURN    = 4'd4;
    localparam logic [3:0] OP_SET_ALG   = 4'd5;
    localparam logic [3:0] OP_WRITE_PIX = 4'd6;

    state_t              state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                strobe_s;
    logic                strobe_prev;
    logic                ack;
    logic                result_ready;
    logic                cmd_error;
    logic [2:0]          zoom_q;
    logic [3:0]          opcode_q;
    logic [15:0]         count_field;

    logic [3:0]          opcode;
    logic [3:0]          switches;
    logic [ADDR_W-1:0]   addr_field;
    logic                addr_ok;
    logic                clear_rr;
    logic                ready;
    wire                 unused_ok = &{1'b0, hps_data_in};

    // The synchroniser is deliberately not reset so a strobe held high across reset stays high.
    always_ff @(posedge CLOCK_50) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], hps_control_in};
    end

    assign strobe_s   = sync_q[SYNC_STAGES-1];
    assign opcode     = hps_data_in[31:28];
    assign switches   = hps_data_in[3:0];
    assign addr_field = hps_data_in[8 +: ADDR_W];
    assign addr_ok    = 32'(addr_field) < 32'(RAM_DEPTH);
    assign clear_rr   = (opcode_q == OP_RESET) || (opcode_q == OP_ZOOM_IN) ||
                        (opcode_q == OP_ZOOM_OUT) || (opcode_q == OP_RETURN);
    assign ready      = (state == IDLE) && !strobe_s;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state                 <= IDLE;
            strobe_prev           <= 1'b1;
            ack                   <= 1'b0;
            cmd_reset_pulse       <= 1'b0;
            cmd_zoom_in_pulse     <= 1'b0;
            cmd_zoom_out_pulse    <= 1'b0;
            cmd_return_pulse      <= 1'b0;
            cmd_algorithm_select  <= 2'd0;
            cmd_multiple_sw_error <= 1'b0;
            cmd_no_sw_error       <= 1'b1;
            ram_wraddress         <= '0;
            ram_data_in           <= '0;
            ram_wren              <= 1'b0;
            result_ready          <= 1'b0;
            cmd_error             <= 1'b0;
            zoom_q                <= 3'd0;
            opcode_q              <= 4'd0;
        end else begin
            cmd_reset_pulse    <= 1'b0;
            cmd_zoom_in_pulse  <= 1'b0;
            cmd_zoom_out_pulse <= 1'b0;
            cmd_return_pulse   <= 1'b0;
            ram_wren           <= 1'b0;
            zoom_q             <= controller_zoom_level;
            strobe_prev        <= strobe_s;

            // A clear in the EXEC cycle beats a coincident controller_done.
            if (state == EXEC && clear_rr) begin
                result_ready <= 1'b0;
            end else if (controller_done) begin
                result_ready <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (strobe_s && !strobe_prev) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    opcode_q <= opcode;
                    state    <= EXEC;
                    case (opcode)
                        OP_NOP: cmd_error <= 1'b0;
                        OP_RESET: begin
                            cmd_reset_pulse       <= 1'b1;
                            cmd_algorithm_select  <= 2'd0;
                            cmd_no_sw_error       <= 1'b1;
                            cmd_multiple_sw_error <= 1'b0;
                            cmd_error             <= 1'b0;
                        end
                        OP_ZOOM_IN: begin
                            cmd_zoom_in_pulse <= 1'b1;
                            cmd_error         <= 1'b0;
                        end
                        OP_ZOOM_OUT: begin
                            cmd_zoom_out_pulse <= 1'b1;
                            cmd_error          <= 1'b0;
                        end
                        OP_RETURN: begin
                            cmd_return_pulse <= 1'b1;
                            cmd_error        <= 1'b0;
                        end
                        OP_SET_ALG: begin
                            cmd_error <= 1'b0;
                            case (switches)
                                4'b0000: begin
                                    cmd_no_sw_error       <= 1'b1;
                                    cmd_multiple_sw_error <= 1'b0;
                                end
                                4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
                                    cmd_no_sw_error       <= 1'b0;
                                    cmd_multiple_sw_error <= 1'b0;
                                    case (switches)
                                        4'b0010: cmd_algorithm_select <= 2'd1;
                                        4'b0100: cmd_algorithm_select <= 2'd2;
                                        4'b1000: cmd_algorithm_select <= 2'd3;
                                        default: cmd_algorithm_select <= 2'd0;
                                    endcase
                                end
                                default: begin
                                    cmd_no_sw_error       <= 1'b0;
                                    cmd_multiple_sw_error <= 1'b1;
                                end
                            endcase
                        end
                        OP_WRITE_PIX: begin
                            if (addr_ok) begin
                                ram_wren      <= 1'b1;
                                ram_wraddress <= addr_field;
                                ram_data_in   <= hps_data_in[PIX_W-1:0];
                                cmd_error     <= 1'b0;
                            end else begin
                                cmd_error <= 1'b1;
                            end
                        end
                        default: cmd_error <= 1'b1;
                    endcase
                end
                EXEC: begin
                    ack   <= 1'b1;
                    state <= ACK_WAIT;
                end
                ACK_WAIT: begin
                    if (!strobe_s) begin
                        ack   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HPS_CMD_COUNT_EN
    logic [15:0] cmd_count;

    // Every command leaves EXEC exactly once, at the edge that raises ack.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cmd_count <= 16'd0;
        end else if (state == EXEC) begin
            cmd_count <= cmd_count + 16'd1;
        end
    end

    assign count_field = cmd_count;
`else
    assign count_field = 16'd0;
`endif

    assign fpga_status_out = {count_field, 5'd0, cmd_error, ack, cmd_multiple_sw_error,
                              cmd_no_sw_error, cmd_algorithm_select, zoom_q,
                              result_ready, ready};
    assign debug_state     = state;

endmodule

// File: tb/tb_hps_command_decoder.sv
// Directed bench for hps_command_decoder: vector table of full handshakes plus timing,
// result_ready and mid-handshake reset sequences.
module tb_hps_command_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] hps_data_in;
    logic        hps_control_in;
    logic        controller_done;
    logic [2:0]  controller_zoom_level;
    logic [31:0] fpga_status_out;
    logic        cmd_reset_pulse, cmd_zoom_in_pulse, cmd_zoom_out_pulse, cmd_return_pulse;
    logic [1:0]  cmd_algorithm_select;
    logic        cmd_multiple_sw_error, cmd_no_sw_error;
    logic [14:0] ram_wraddress;
    logic [7:0]  ram_data_in;
    logic        ram_wren;
    logic [1:0]  debug_state;

    always #10 clk = ~clk;

    hps_command_decoder dut (
        .CLOCK_50              (clk),
        .reset                 (reset),
        .hps_data_in           (hps_data_in),
        .hps_control_in        (hps_control_in),
        .controller_done       (controller_done),
        .controller_zoom_level (controller_zoom_level),
        .fpga_status_out       (fpga_status_out),
        .cmd_reset_pulse       (cmd_reset_pulse),
        .cmd_zoom_in_pulse     (cmd_zoom_in_pulse),
        .cmd_zoom_out_pulse    (cmd_zoom_out_pulse),
        .cmd_return_pulse      (cmd_return_pulse),
        .cmd_algorithm_select  (cmd_algorithm_select),
        .cmd_multiple_sw_error (cmd_multiple_sw_error),
        .cmd_no_sw_error       (cmd_no_sw_error),
        .ram_wraddress         (ram_wraddress),
        .ram_data_in           (ram_data_in),
        .ram_wren              (ram_wren),
        .debug_state           (debug_state)
    );

    typedef struct {
        logic [31:0] word;
        logic [4:0]  pulses;   // {reset, zoom_in, zoom_out, return, wren}
        logic [10:0] status;
        logic [14:0] addr;
        logic [7:0]  data;
    } vec_t;

    vec_t        vecs[17];
    int          checks = 0;
    int          errors = 0;
    int          n_p[5];
    logic [14:0] seen_addr;
    logic [7:0]  seen_data;
    logic [15:0] exp_cnt;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_count();
`ifdef HPS_CMD_COUNT_EN
        return exp_cnt;
`else
        return 16'd0;
`endif
    endfunction

    task automatic clear_seen();
        for (int i = 0; i < 5; i++) n_p[i] = 0;
    endtask

    task automatic sample_pulses();
        if (ram_wren) begin
            n_p[0]++;
            seen_addr = ram_wraddress;
            seen_data = ram_data_in;
        end
        if (cmd_return_pulse)   n_p[1]++;
        if (cmd_zoom_out_pulse) n_p[2]++;
        if (cmd_zoom_in_pulse)  n_p[3]++;
        if (cmd_reset_pulse)    n_p[4]++;
    endtask

    // Full handshake starting and ending on a negedge; pulses are tallied throughout.
    task automatic do_cmd(input logic [31:0] w);
        clear_seen();
        hps_data_in    = w;
        hps_control_in = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); @(negedge clk);
            sample_pulses();
            if (fpga_status_out[9]) break;
        end
        check("ack_rise", {63'd0, fpga_status_out[9]}, 64'd1);
        exp_cnt++;
        hps_control_in = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); @(negedge clk);
            sample_pulses();
            if (!fpga_status_out[9] && fpga_status_out[0]) break;
        end
        check("ack_fall", {62'd0, fpga_status_out[9], fpga_status_out[0]}, 64'd1);
    endtask

    function automatic logic [9:0] pulse_code_got();
        logic [9:0] c;
        for (int i = 0; i < 5; i++) c[2*i +: 2] = (n_p[i] > 3) ? 2'd3 : 2'(n_p[i]);
        return c;
    endfunction

    function automatic logic [9:0] pulse_code_exp(input logic [4:0] p);
        logic [9:0] c;
        for (int i = 0; i < 5; i++) c[2*i +: 2] = {1'b0, p[i]};
        return c;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h6000_4A7F, 5'b00001, 11'h081, 15'h004A, 8'h7F};
        vecs[1]  = '{32'h604B_0011, 5'b00000, 11'h481, 15'h0, 8'h0};
        vecs[2]  = '{32'h5000_0004, 5'b00000, 11'h041, 15'h0, 8'h0};
        vecs[3]  = '{32'h5000_0000, 5'b00000, 11'h0C1, 15'h0, 8'h0};
        vecs[4]  = '{32'h5000_0004, 5'b00000, 11'h041, 15'h0, 8'h0};
        vecs[5]  = '{32'h5000_0006, 5'b00000, 11'h141, 15'h0, 8'h0};
        vecs[6]  = '{32'hF000_0000, 5'b00000, 11'h541, 15'h0, 8'h0};
        vecs[7]  = '{32'h0000_0000, 5'b00000, 11'h141, 15'h0, 8'h0};
        vecs[8]  = '{32'h3000_0000, 5'b00100, 11'h141, 15'h0, 8'h0};
        vecs[9]  = '{32'h4000_0000, 5'b00010, 11'h141, 15'h0, 8'h0};
        vecs[10] = '{32'h7123_4567, 5'b00000, 11'h541, 15'h0, 8'h0};
        vecs[11] = '{32'h1000_0000, 5'b10000, 11'h081, 15'h0, 8'h0};
        vecs[12] = '{32'h6000_0001, 5'b00001, 11'h081, 15'h0000, 8'h01};
        vecs[13] = '{32'h604A_FF5A, 5'b00001, 11'h081, 15'h4AFF, 8'h5A};
        vecs[14] = '{32'h5000_0008, 5'b00000, 11'h061, 15'h0, 8'h0};
        vecs[15] = '{32'h5000_0001, 5'b00000, 11'h001, 15'h0, 8'h0};
        vecs[16] = '{32'h2000_0000, 5'b01000, 11'h001, 15'h0, 8'h0};

        // Clock/reset
        reset = 1'b1; hps_data_in = 32'd0; hps_control_in = 1'b0;
        controller_done = 1'b0; controller_zoom_level = 3'd0;
        exp_cnt = 16'd0; seen_addr = '0; seen_data = '0;
        repeat (4) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); @(negedge clk);

        // T1: reset state
        check("reset_status", {32'd0, fpga_status_out}, 64'h81);
        check("reset_pulses", {59'd0, cmd_reset_pulse, cmd_zoom_in_pulse, cmd_zoom_out_pulse,
                               cmd_return_pulse, ram_wren}, 64'd0);
        check("reset_state", {62'd0, debug_state}, 64'd0);

        // T2: exact latency of a ZOOM_IN
        hps_data_in = 32'h2000_0000; hps_control_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t2_pre_pulse", {63'd0, cmd_zoom_in_pulse}, 64'd0);
        check("t2_capture_notready", {63'd0, fpga_status_out[0]}, 64'd0);
        @(posedge clk); @(negedge clk);
        check("t2_pulse", {62'd0, cmd_zoom_in_pulse, fpga_status_out[9]}, 64'h2);
        @(posedge clk); @(negedge clk);
        check("t2_ack", {62'd0, cmd_zoom_in_pulse, fpga_status_out[9]}, 64'h1);
        exp_cnt++;
        hps_control_in = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t2_release", {32'd0, fpga_status_out}, {32'd0, exp_count(), 16'h0081});

        // T3/T4 and the rest of the command set, table driven
        for (int v = 0; v < 17; v++) begin
            do_cmd(vecs[v].word);
            check($sformatf("v%0d_pulses", v), {54'd0, pulse_code_got()},
                  {54'd0, pulse_code_exp(vecs[v].pulses)});
            check($sformatf("v%0d_status", v), {53'd0, fpga_status_out[10:0]},
                  {53'd0, vecs[v].status});
            check($sformatf("v%0d_count", v), {48'd0, fpga_status_out[31:16]},
                  {48'd0, exp_count()});
            if (vecs[v].pulses[0]) begin
                check($sformatf("v%0d_wr", v), {41'd0, seen_addr, seen_data},
                      {41'd0, vecs[v].addr, vecs[v].data});
            end
        end

        // T5: result_ready set by done, survives a NOP, cleared by a coincident ZOOM_OUT
        controller_done = 1'b1;
        @(posedge clk); @(negedge clk);
        controller_done = 1'b0;
        check("t5_rr_set", {63'd0, fpga_status_out[1]}, 64'd1);
        do_cmd(32'h0000_0000);
        check("t5_rr_nop", {63'd0, fpga_status_out[1]}, 64'd1);
        hps_data_in = 32'h3000_0000; hps_control_in = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t5_zo_pulse", {63'd0, cmd_zoom_out_pulse}, 64'd1);
        controller_done = 1'b1;
        @(posedge clk); @(negedge clk);
        controller_done = 1'b0;
        check("t5_rr_clear", {62'd0, fpga_status_out[9], fpga_status_out[1]}, 64'h2);
        exp_cnt++;
        hps_control_in = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t5_idle", {32'd0, fpga_status_out}, {32'd0, exp_count(), 16'h0001});

        // Zoom level passes through one register
        controller_zoom_level = 3'd5;
        @(posedge clk); @(negedge clk);
        check("zoom_level", {61'd0, fpga_status_out[4:2]}, 64'd5);
        controller_zoom_level = 3'd0;

        // T6: reset while in ACK_WAIT with the strobe still high
        hps_data_in = 32'h2000_0000; hps_control_in = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); @(negedge clk);
            if (fpga_status_out[9]) break;
        end
        check("t6_ack_wait", {62'd0, debug_state}, 64'd3);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        exp_cnt = 16'd0;
        check("t6_after_reset", {32'd0, fpga_status_out}, 64'h80);
        clear_seen();
        repeat (8) begin
            @(posedge clk); @(negedge clk);
            sample_pulses();
        end
        check("t6_no_retrigger", {54'd0, pulse_code_got()}, 64'd0);
        check("t6_idle_held", {62'd0, debug_state}, 64'd0);
        hps_control_in = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t6_ready", {32'd0, fpga_status_out}, 64'h81);
        do_cmd(32'h2000_0000);
        check("t6_new_cmd", {54'd0, pulse_code_got()}, {54'd0, pulse_code_exp(5'b01000)});
        check("t6_count", {48'd0, fpga_status_out[31:16]}, {48'd0, exp_count()});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
